// File: rtl/ddr_pkg.sv
// Shared AXI encodings, FSM state types and helpers for the multi-port DDR arbiter.
package ddr_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_state_e;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr_i, modulo N.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [IDX_W:0] cand;
    logic           found;

    // NOTE: every signal driven here gets a default first, so no path can leave one unassigned and infer a latch.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < N; i++) begin
            cand = {1'b0, ptr_i} + (IDX_W+1)'(i);
            if (cand >= (IDX_W+1)'(N)) cand = cand - (IDX_W+1)'(N);
            if (!found && req_i[cand[IDX_W-1:0]]) begin
                found                  = 1'b1;
                gnt_o[cand[IDX_W-1:0]] = 1'b1;
                idx_o                  = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/axi_ddr_port_arbiter.sv
// Round-robin multiplexer of NUM_PORTS AXI4 masters onto the single MIG slave port;
// read and write directions arbitrate independently, one burst in flight each.
module axi_ddr_port_arbiter
    import ddr_pkg::*;
#(
    parameter int         NUM_PORTS  = 4,
    parameter int         IDX_W      = clog2(NUM_PORTS),
    parameter int         ADDR_W     = 30,
    parameter int         AXI_WIDTH  = 64,
    parameter logic [2:0] AXI_AXSIZE = 3'b011
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_PORTS*ADDR_W-1:0]     s_awaddr,
    input  logic [NUM_PORTS*8-1:0]          s_awlen,
    input  logic [NUM_PORTS-1:0]            s_awvalid,
    output logic [NUM_PORTS-1:0]            s_awready,
    input  logic [NUM_PORTS*AXI_WIDTH-1:0]  s_wdata,
    input  logic [NUM_PORTS*AXI_WIDTH/8-1:0] s_wstrb,
    input  logic [NUM_PORTS-1:0]            s_wlast,
    input  logic [NUM_PORTS-1:0]            s_wvalid,
    output logic [NUM_PORTS-1:0]            s_wready,
    output logic [1:0]                      s_bresp,
    output logic [NUM_PORTS-1:0]            s_bvalid,
    input  logic [NUM_PORTS-1:0]            s_bready,
    input  logic [NUM_PORTS*ADDR_W-1:0]     s_araddr,
    input  logic [NUM_PORTS*8-1:0]          s_arlen,
    input  logic [NUM_PORTS-1:0]            s_arvalid,
    output logic [NUM_PORTS-1:0]            s_arready,
    output logic [AXI_WIDTH-1:0]            s_rdata,
    output logic [1:0]                      s_rresp,
    output logic                            s_rlast,
    output logic [NUM_PORTS-1:0]            s_rvalid,
    input  logic [NUM_PORTS-1:0]            s_rready,
    output logic [IDX_W-1:0]                m_awid,
    output logic [ADDR_W-1:0]               m_awaddr,
    output logic [7:0]                      m_awlen,
    output logic [2:0]                      m_awsize,
    output logic [1:0]                      m_awburst,
    output logic                            m_awlock,
    output logic [3:0]                      m_awcache,
    output logic [2:0]                      m_awprot,
    output logic [3:0]                      m_awqos,
    output logic                            m_awvalid,
    input  logic                            m_awready,
    output logic [AXI_WIDTH-1:0]            m_wdata,
    output logic [AXI_WIDTH/8-1:0]          m_wstrb,
    output logic                            m_wlast,
    output logic                            m_wvalid,
    input  logic                            m_wready,
    input  logic [1:0]                      m_bresp,
    input  logic                            m_bvalid,
    output logic                            m_bready,
    output logic [IDX_W-1:0]                m_arid,
    output logic [ADDR_W-1:0]               m_araddr,
    output logic [7:0]                      m_arlen,
    output logic [2:0]                      m_arsize,
    output logic [1:0]                      m_arburst,
    output logic                            m_arlock,
    output logic [3:0]                      m_arcache,
    output logic [2:0]                      m_arprot,
    output logic [3:0]                      m_arqos,
    output logic                            m_arvalid,
    input  logic                            m_arready,
    input  logic [AXI_WIDTH-1:0]            m_rdata,
    input  logic [1:0]                      m_rresp,
    input  logic                            m_rlast,
    input  logic                            m_rvalid,
    output logic                            m_rready,
    output logic [IDX_W-1:0]                wr_grant,
    output logic [IDX_W-1:0]                rd_grant,
    output logic                            wr_busy,
    output logic                            rd_busy
);

    localparam int SW = AXI_WIDTH / 8;

    wr_state_e           wr_state_q, wr_state_d;
    rd_state_e           rd_state_q, rd_state_d;
    logic [IDX_W-1:0]    wr_grant_q, wr_grant_d, wr_ptr_q, wr_ptr_d;
    logic [IDX_W-1:0]    rd_grant_q, rd_grant_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0]   awaddr_q, awaddr_d, araddr_q, araddr_d;
    logic [7:0]          awlen_q, awlen_d, arlen_q, arlen_d;
    logic [NUM_PORTS-1:0] wr_oh, rd_oh;
    logic [IDX_W-1:0]    wr_idx, rd_idx;

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] g);
        return (g == IDX_W'(NUM_PORTS - 1)) ? '0 : g + IDX_W'(1);
    endfunction

    rr_arbiter #(.N(NUM_PORTS), .IDX_W(IDX_W)) u_wr_arb (
        .req_i(s_awvalid), .ptr_i(wr_ptr_q), .gnt_o(wr_oh), .idx_o(wr_idx)
    );

    rr_arbiter #(.N(NUM_PORTS), .IDX_W(IDX_W)) u_rd_arb (
        .req_i(s_arvalid), .ptr_i(rd_ptr_q), .gnt_o(rd_oh), .idx_o(rd_idx)
    );

    always_comb begin
        wr_state_d = wr_state_q;
        wr_grant_d = wr_grant_q;
        wr_ptr_d   = wr_ptr_q;
        awaddr_d   = awaddr_q;
        awlen_d    = awlen_q;
        m_awvalid  = 1'b0;
        m_wvalid   = 1'b0;
        m_bready   = 1'b0;
        s_awready  = '0;
        s_wready   = '0;
        s_bvalid   = '0;
        case (wr_state_q)
            W_IDLE: if (|wr_oh) begin
                wr_grant_d = wr_idx;
                awaddr_d   = s_awaddr[wr_idx*ADDR_W +: ADDR_W];
                awlen_d    = s_awlen[wr_idx*8 +: 8];
                wr_state_d = W_ADDR;
            end
            W_ADDR: begin
                m_awvalid             = 1'b1;
                s_awready[wr_grant_q] = m_awready;
                if (m_awready) wr_state_d = W_DATA;
            end
            W_DATA: begin
                m_wvalid             = s_wvalid[wr_grant_q];
                s_wready[wr_grant_q] = m_wready;
                if (m_wvalid && m_wready && m_wlast) wr_state_d = W_RESP;
            end
            W_RESP: begin
                s_bvalid[wr_grant_q] = m_bvalid;
                m_bready             = s_bready[wr_grant_q];
                if (m_bvalid && m_bready) begin
                    wr_ptr_d   = wrap_inc(wr_grant_q);
                    wr_state_d = W_IDLE;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        rd_state_d = rd_state_q;
        rd_grant_d = rd_grant_q;
        rd_ptr_d   = rd_ptr_q;
        araddr_d   = araddr_q;
        arlen_d    = arlen_q;
        m_arvalid  = 1'b0;
        m_rready   = 1'b0;
        s_arready  = '0;
        s_rvalid   = '0;
        case (rd_state_q)
            R_IDLE: if (|rd_oh) begin
                rd_grant_d = rd_idx;
                araddr_d   = s_araddr[rd_idx*ADDR_W +: ADDR_W];
                arlen_d    = s_arlen[rd_idx*8 +: 8];
                rd_state_d = R_ADDR;
            end
            R_ADDR: begin
                m_arvalid             = 1'b1;
                s_arready[rd_grant_q] = m_arready;
                if (m_arready) rd_state_d = R_DATA;
            end
            R_DATA: begin
                s_rvalid[rd_grant_q] = m_rvalid;
                m_rready             = s_rready[rd_grant_q];
                if (m_rvalid && m_rready && m_rlast) begin
                    rd_ptr_d   = wrap_inc(rd_grant_q);
                    rd_state_d = R_IDLE;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state_q <= W_IDLE;
            rd_state_q <= R_IDLE;
            wr_grant_q <= '0;
            rd_grant_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            awaddr_q   <= '0;
            araddr_q   <= '0;
            awlen_q    <= '0;
            arlen_q    <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            wr_grant_q <= wr_grant_d;
            rd_grant_q <= rd_grant_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            awaddr_q   <= awaddr_d;
            araddr_q   <= araddr_d;
            awlen_q    <= awlen_d;
            arlen_q    <= arlen_d;
        end
    end

    // Data/response paths are pure muxes; only the handshakes depend on FSM state.
    assign m_wdata   = s_wdata[wr_grant_q*AXI_WIDTH +: AXI_WIDTH];
    assign m_wstrb   = s_wstrb[wr_grant_q*SW +: SW];
    assign m_wlast   = s_wlast[wr_grant_q];
    assign s_bresp   = m_bresp;
    assign s_rdata   = m_rdata;
    assign s_rresp   = m_rresp;
    assign s_rlast   = m_rlast;

    assign m_awid    = wr_grant_q;
    assign m_awaddr  = awaddr_q;
    assign m_awlen   = awlen_q;
    assign m_awsize  = AXI_AXSIZE;
    assign m_awburst = AXI_BURST_INCR;
    assign m_awlock  = 1'b0;
    assign m_awcache = 4'b0000;
    assign m_awprot  = 3'b000;
    assign m_awqos   = 4'b0000;

    assign m_arid    = rd_grant_q;
    assign m_araddr  = araddr_q;
    assign m_arlen   = arlen_q;
    assign m_arsize  = AXI_AXSIZE;
    assign m_arburst = AXI_BURST_INCR;
    assign m_arlock  = 1'b0;
    assign m_arcache = 4'b0000;
    assign m_arprot  = 3'b000;
    assign m_arqos   = 4'b0000;

    assign wr_grant  = wr_grant_q;
    assign rd_grant  = rd_grant_q;
    assign wr_busy   = (wr_state_q != W_IDLE);
    assign rd_busy   = (rd_state_q != R_IDLE);

endmodule

// File: tb/tb_axi_ddr_port_arbiter.sv
// Directed bench for axi_ddr_port_arbiter: the bench plays both the upstream masters and the MIG.
module tb_axi_ddr_port_arbiter;

    localparam int NP = 4;
    localparam int IW = 2;
    localparam int AW = 30;
    localparam int DW = 64;
    localparam int SW = DW / 8;

    logic clk = 1'b0;
    logic rst_n;

    logic [NP*AW-1:0] s_awaddr, s_araddr;
    logic [NP*8-1:0]  s_awlen, s_arlen;
    logic [NP-1:0]    s_awvalid, s_awready, s_wlast, s_wvalid, s_wready;
    logic [NP*DW-1:0] s_wdata;
    logic [NP*SW-1:0] s_wstrb;
    logic [1:0]       s_bresp, s_rresp;
    logic [NP-1:0]    s_bvalid, s_bready, s_arvalid, s_arready, s_rvalid, s_rready;
    logic [DW-1:0]    s_rdata;
    logic             s_rlast;

    logic [IW-1:0] m_awid, m_arid;
    logic [AW-1:0] m_awaddr, m_araddr;
    logic [7:0]    m_awlen, m_arlen;
    logic [2:0]    m_awsize, m_arsize, m_awprot, m_arprot;
    logic [1:0]    m_awburst, m_arburst, m_bresp, m_rresp;
    logic          m_awlock, m_arlock;
    logic [3:0]    m_awcache, m_arcache, m_awqos, m_arqos;
    logic          m_awvalid, m_awready, m_wlast, m_wvalid, m_wready;
    logic          m_bvalid, m_bready, m_arvalid, m_arready;
    logic          m_rlast, m_rvalid, m_rready;
    logic [DW-1:0] m_wdata, m_rdata;
    logic [SW-1:0] m_wstrb;
    logic [IW-1:0] wr_grant, rd_grant;
    logic          wr_busy, rd_busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    axi_ddr_port_arbiter #(
        .NUM_PORTS(NP), .IDX_W(IW), .ADDR_W(AW), .AXI_WIDTH(DW), .AXI_AXSIZE(3'b011)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid),
        .s_wready(s_wready), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rvalid(s_rvalid),
        .s_rready(s_rready),
        .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
        .m_awburst(m_awburst), .m_awlock(m_awlock), .m_awcache(m_awcache), .m_awprot(m_awprot),
        .m_awqos(m_awqos), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid),
        .m_wready(m_wready), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
        .m_arburst(m_arburst), .m_arlock(m_arlock), .m_arcache(m_arcache), .m_arprot(m_arprot),
        .m_arqos(m_arqos), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rvalid(m_rvalid),
        .m_rready(m_rready),
        .wr_grant(wr_grant), .rd_grant(rd_grant), .wr_busy(wr_busy), .rd_busy(rd_busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] wbeat(input int p, input int b);
        return {16'hA5A5, 16'(p), 32'(b)};
    endfunction

    function automatic logic [63:0] rbeat(input int p, input int b);
        return {16'h5A5A, 16'(p), 32'(b * 3 + 1)};
    endfunction

    task automatic aw_req(input int p, input logic [AW-1:0] addr, input logic [7:0] len);
        s_awaddr[p*AW +: AW] = addr;
        s_awlen[p*8 +: 8]    = len;
        s_awvalid[p]         = 1'b1;
    endtask

    task automatic ar_req(input int p, input logic [AW-1:0] addr, input logic [7:0] len);
        s_araddr[p*AW +: AW] = addr;
        s_arlen[p*8 +: 8]    = len;
        s_arvalid[p]         = 1'b1;
    endtask

    task automatic reset_check(input string tag);
        chk({tag, "_vr"}, 64'({s_awready, s_wready, s_bvalid, s_arready, s_rvalid, m_awvalid,
                               m_wvalid, m_bready, m_arvalid, m_rready, wr_busy, rd_busy}), 64'd0);
        chk({tag, "_grant"}, 64'({wr_grant, rd_grant}), 64'd0);
        chk({tag, "_len"}, 64'({m_awlen, m_arlen}), 64'd0);
        chk({tag, "_awaddr"}, 64'(m_awaddr), 64'd0);
        chk({tag, "_araddr"}, 64'(m_araddr), 64'd0);
    endtask

    // Requester g must already be raised; completes one write burst of nb beats.
    task automatic wr_burst(input int g, input int nb, input logic [AW-1:0] addr, input int stall);
        logic [NP-1:0] oh;
        oh = NP'(1 << g);
        tick();
        chk("aw_grant", 64'(wr_grant), 64'(g));
        chk("aw_valid", 64'({m_awvalid, wr_busy}), 64'b11);
        chk("aw_id", 64'(m_awid), 64'(g));
        chk("aw_addr", 64'(m_awaddr), 64'(addr));
        chk("aw_len", 64'(m_awlen), 64'(nb - 1));
        chk("aw_ready_idle", 64'(s_awready), 64'd0);
        m_awready = 1'b1;
        #1;
        chk("aw_ready", 64'(s_awready), 64'(oh));
        tick();
        m_awready    = 1'b0;
        s_awvalid[g] = 1'b0;
        for (int b = 0; b < nb; b++) begin
            s_wdata[g*DW +: DW] = wbeat(g, b);
            s_wstrb[g*SW +: SW] = 8'hF0 ^ 8'(b);
            s_wvalid[g]         = 1'b1;
            s_wlast[g]          = (b == nb - 1);
            if (b == 0) begin
                for (int s = 0; s < stall; s++) begin
                    m_wready = 1'b0;
                    #1;
                    chk("stall_wvalid", 64'(m_wvalid), 64'd1);
                    chk("stall_wready", 64'(s_wready), 64'd0);
                    tick();
                end
            end
            m_wready = 1'b1;
            #1;
            chk("w_valid", 64'({m_wvalid, m_wlast}), 64'({1'b1, b == nb - 1}));
            chk("w_data", m_wdata, wbeat(g, b));
            chk("w_strb", 64'(m_wstrb), 64'(8'hF0 ^ 8'(b)));
            chk("w_ready", 64'(s_wready), 64'(oh));
            tick();
        end
        m_wready = 1'b0;
        chk("w_done", 64'(m_wvalid), 64'd0);
        s_wvalid[g] = 1'b0;
        s_wlast[g]  = 1'b0;
        m_bvalid    = 1'b1;
        m_bresp     = 2'(g);
        s_bready[g] = 1'b1;
        #1;
        chk("b_valid", 64'(s_bvalid), 64'(oh));
        chk("b_ready", 64'({m_bready, s_bresp}), 64'({1'b1, 2'(g)}));
        tick();
        m_bvalid    = 1'b0;
        s_bready[g] = 1'b0;
        chk("wr_idle", 64'(wr_busy), 64'd0);
    endtask

    // Requester g must already be raised; SLVERR is returned on beat index err (-1 for none).
    task automatic rd_burst(input int g, input int nb, input logic [AW-1:0] addr, input int err);
        logic [NP-1:0] oh;
        oh = NP'(1 << g);
        tick();
        chk("ar_grant", 64'(rd_grant), 64'(g));
        chk("ar_valid", 64'({m_arvalid, rd_busy}), 64'b11);
        chk("ar_id", 64'(m_arid), 64'(g));
        chk("ar_addr", 64'(m_araddr), 64'(addr));
        chk("ar_len", 64'(m_arlen), 64'(nb - 1));
        m_arready = 1'b1;
        #1;
        chk("ar_ready", 64'(s_arready), 64'(oh));
        tick();
        m_arready    = 1'b0;
        s_arvalid[g] = 1'b0;
        for (int b = 0; b < nb; b++) begin
            m_rvalid    = 1'b1;
            m_rdata     = rbeat(g, b);
            m_rresp     = (b == err) ? 2'b10 : 2'b00;
            m_rlast     = (b == nb - 1);
            s_rready[g] = 1'b1;
            #1;
            chk("r_valid", 64'(s_rvalid), 64'(oh));
            chk("r_ready", 64'(m_rready), 64'd1);
            chk("r_data", s_rdata, rbeat(g, b));
            chk("r_resp_last", 64'({s_rresp, s_rlast}), 64'({(b == err) ? 2'b10 : 2'b00, b == nb - 1}));
            tick();
        end
        m_rvalid    = 1'b0;
        m_rlast     = 1'b0;
        m_rresp     = 2'b00;
        s_rready[g] = 1'b0;
        chk("rd_idle", 64'(rd_busy), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        s_awaddr = '0; s_awlen = '0; s_awvalid = '0;
        s_wdata = '0; s_wstrb = '0; s_wlast = '0; s_wvalid = '0; s_bready = '0;
        s_araddr = '0; s_arlen = '0; s_arvalid = '0; s_rready = '0;
        m_awready = 1'b0; m_wready = 1'b0; m_bresp = 2'b00; m_bvalid = 1'b0;
        m_arready = 1'b0; m_rdata = '0; m_rresp = 2'b00; m_rlast = 1'b0; m_rvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_check("por");
        chk("fixed_attrs", 64'({m_awsize, m_awburst, m_awlock, m_awcache, m_awprot, m_awqos,
                                m_arsize, m_arburst, m_arlock, m_arcache, m_arprot, m_arqos}),
            64'({3'b011, 2'b01, 12'd0, 3'b011, 2'b01, 12'd0}));
        rst_n = 1'b1;
        tick();

        // Lone 8-beat write from port 2, then 1 and 3 together: pointer at 3 picks 3 first.
        aw_req(2, 30'h100, 8'd7);
        wr_burst(2, 8, 30'h100, 0);
        aw_req(1, 30'h180, 8'd0);
        aw_req(3, 30'h1C0, 8'd0);
        wr_burst(3, 1, 30'h1C0, 0);
        wr_burst(1, 1, 30'h180, 0);

        rst_n = 1'b0;
        #1;
        reset_check("rst1");
        tick();
        rst_n = 1'b1;
        tick();

        // All four request; port 0 re-requests after its burst and must wait for port 3.
        for (int p = 0; p < NP; p++) aw_req(p, 30'h1000 + 30'(p * 'h40), 8'd3);
        wr_burst(0, 4, 30'h1000, 0);
        aw_req(0, 30'h2000, 8'd3);
        wr_burst(1, 4, 30'h1040, 0);
        wr_burst(2, 4, 30'h1080, 0);
        wr_burst(3, 4, 30'h10C0, 0);
        wr_burst(0, 4, 30'h2000, 0);

        // Overlapping 16-beat write on port 1 and 16-beat read on port 3.
        aw_req(1, 30'h3000, 8'd15);
        ar_req(3, 30'h4000, 8'd15);
        tick();
        chk("ovl_grants", 64'({wr_grant, rd_grant}), 64'({2'd1, 2'd3}));
        chk("ovl_ar", 64'({m_arvalid, m_arid, m_arlen}), 64'({1'b1, 2'd3, 8'd15}));
        chk("ovl_araddr", 64'(m_araddr), 64'(30'h4000));
        m_awready = 1'b1;
        m_arready = 1'b1;
        #1;
        chk("ovl_axready", 64'({s_awready, s_arready}), 64'({4'b0010, 4'b1000}));
        tick();
        m_awready = 1'b0; m_arready = 1'b0; s_awvalid[1] = 1'b0; s_arvalid[3] = 1'b0;
        for (int b = 0; b < 16; b++) begin
            s_wdata[1*DW +: DW] = wbeat(1, b);
            s_wvalid[1] = 1'b1;
            s_wlast[1]  = (b == 15);
            m_wready    = 1'b1;
            m_rvalid    = 1'b1;
            m_rdata     = rbeat(3, b);
            m_rlast     = (b == 15);
            s_rready[3] = 1'b1;
            #1;
            chk("ovl_route", 64'({m_wvalid, s_wready, s_rvalid, m_rready}),
                64'({1'b1, 4'b0010, 4'b1000, 1'b1}));
            chk("ovl_wdata", m_wdata, wbeat(1, b));
            chk("ovl_rdata", s_rdata, rbeat(3, b));
            chk("ovl_hold", 64'({wr_grant, rd_grant}), 64'({2'd1, 2'd3}));
            tick();
        end
        s_wvalid[1] = 1'b0; s_wlast[1] = 1'b0; m_wready = 1'b0;
        m_rvalid = 1'b0; m_rlast = 1'b0; s_rready[3] = 1'b0;
        chk("ovl_busy", 64'({wr_busy, rd_busy}), 64'b10);
        m_bvalid = 1'b1; s_bready[1] = 1'b1;
        #1;
        chk("ovl_bvalid", 64'({s_bvalid, m_bready}), 64'({4'b0010, 1'b1}));
        tick();
        m_bvalid = 1'b0; s_bready[1] = 1'b0;
        chk("ovl_done", 64'({wr_busy, rd_busy}), 64'b00);

        // Single-beat write with the MIG holding off wready for 5 cycles.
        aw_req(2, 30'h5000, 8'd0);
        wr_burst(2, 1, 30'h5000, 5);

        // 8-beat read with SLVERR on beat 3.
        ar_req(2, 30'h6000, 8'd7);
        rd_burst(2, 8, 30'h6000, 3);

        // Reset asserted with a write on port 2 four beats in.
        aw_req(2, 30'h7000, 8'd7);
        tick();
        chk("mid_grant", 64'(wr_grant), 64'd2);
        m_awready = 1'b1;
        tick();
        m_awready = 1'b0;
        s_awvalid[2] = 1'b0;
        for (int b = 0; b < 4; b++) begin
            s_wdata[2*DW +: DW] = wbeat(2, b);
            s_wvalid[2] = 1'b1;
            m_wready    = 1'b1;
            #1;
            chk("mid_wready", 64'(s_wready), 64'b0100);
            tick();
        end
        rst_n = 1'b0;
        #1;
        reset_check("mid");
        m_wready = 1'b0;
        s_wvalid[2] = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // Pointers back at 0: ports 1 and 3 both request, 1 wins in each direction.
        aw_req(1, 30'h8000, 8'd1);
        aw_req(3, 30'h9000, 8'd0);
        ar_req(1, 30'hA000, 8'd1);
        ar_req(3, 30'hB000, 8'd0);
        wr_burst(1, 2, 30'h8000, 0);
        wr_burst(3, 1, 30'h9000, 0);
        rd_burst(1, 2, 30'hA000, -1);
        rd_burst(3, 1, 30'hB000, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_ddr_port_arbiter.md
Name: axi_ddr_port_arbiter

Overview:
- Multiplexes NUM_PORTS independent AXI4 masters (one axi_ddr_ctrl instance per video/data channel) onto the single AXI4 slave port of the DDR3 MIG.
- Read and write directions are arbitrated independently with round-robin fairness.
- One burst is outstanding per direction.
- Sits between the per-channel controllers and the MIG inside the next-generation multi-channel DDR interface, all in the ui_clk domain.

Parameters:
- NUM_PORTS, 4, number of upstream masters (2..8).
- IDX_W, 2, clog2(NUM_PORTS); also used as the AXI ID width driven to the MIG.
- ADDR_W, 30, AXI address width.
- AXI_WIDTH, 64, AXI data width.
- AXI_AXSIZE, 3'b011, awsize/arsize driven to the MIG; must match AXI_WIDTH.

Ports:
- clk  in  1  ui_clk from the MIG.
- rst_n  in  1  asynchronous active-low reset.
- s_awaddr  in  NUM_PORTS*ADDR_W  packed per-port write address; port i occupies slice i.
- s_awlen  in  NUM_PORTS*8  per-port write burst length.
- s_awvalid / s_awready  in / out  NUM_PORTS  per-port AW handshake.
- s_wdata  in  NUM_PORTS*AXI_WIDTH  per-port write data.
- s_wstrb  in  NUM_PORTS*AXI_WIDTH/8  per-port write strobes.
- s_wlast / s_wvalid / s_wready  in / in / out  NUM_PORTS  per-port W channel.
- s_bresp  out  2  write response, shared by all ports.
- s_bvalid / s_bready  out / in  NUM_PORTS  per-port B handshake.
- s_araddr  in  NUM_PORTS*ADDR_W  per-port read address.
- s_arlen  in  NUM_PORTS*8  per-port read burst length.
- s_arvalid / s_arready  in / out  NUM_PORTS  per-port AR handshake.
- s_rdata  out  AXI_WIDTH  read data, shared by all ports.
- s_rresp  out  2  read response, shared by all ports.
- s_rlast  out  1  last read beat, shared by all ports.
- s_rvalid / s_rready  out / in  NUM_PORTS  per-port R handshake.
- m_aw*, m_w*, m_b*, m_ar*, m_r*  —  MIG-side AXI4 master bundle, same field widths as the MIG's s_axi_* ports.
  - m_awid / m_arid are IDX_W wide.
  - burst = INCR; lock, cache, prot, qos = 0.
- wr_grant  out  IDX_W  currently granted write port.
- rd_grant  out  IDX_W  currently granted read port.
- wr_busy / rd_busy  out  1  high whenever the corresponding FSM is not IDLE.

Behaviour:
- Reset values:
  - All FSMs in IDLE.
  - All valid/ready outputs 0.
  - Grants 0; round-robin pointers 0.
  - m_awaddr, m_araddr, m_awlen, m_arlen 0.
- Write FSM states: W_IDLE, W_ADDR, W_DATA, W_RESP.
  - W_IDLE: if any s_awvalid is high, pick the first requesting port at or after wr_ptr, scanning modulo NUM_PORTS. Register wr_grant, latch awaddr and awlen into the m_aw registers, go to W_ADDR. Grant latency is 1 cycle after the request is seen.
  - W_ADDR: m_awvalid=1 and m_awid=wr_grant. On m_awready, pulse s_awready[wr_grant] in the same cycle (combinational pass-through of m_awready), then go to W_DATA.
  - W_DATA: m_wdata, m_wstrb, m_wlast and m_wvalid are combinational muxes from the granted port. s_wready[g]=m_wready; all other ports' wready=0. On m_wvalid & m_wready & m_wlast, go to W_RESP.
  - W_RESP: m_bvalid is routed to s_bvalid[g] and m_bready=s_bready[g]. On the handshake, set wr_ptr = g+1, wrapping NUM_PORTS-1 to 0, and go to W_IDLE.
- Read FSM states: R_IDLE, R_ADDR, R_DATA.
  - R_IDLE and R_ADDR mirror the write FSM (m_arid = rd_grant).
  - R_DATA: m_rvalid is routed to s_rvalid[g] and m_rready=s_rready[g]. On handshake with m_rlast, set rd_ptr = g+1 (wrapped) and go to R_IDLE.
- Non-granted ports see all ready/valid outputs at 0 at all times.
- Read and write FSMs run concurrently; a read and a write from the same port may be in flight simultaneously.
- Simultaneous requests from all ports are served in rotating order with no starvation. The worst-case wait is NUM_PORTS-1 bursts.
- A port whose valid stays high is not re-granted until the other requesters have been served; the pointer always advances past the last winner.
- awlen=0 (single beat) is legal: W_DATA completes on the first beat.
- m_bresp and m_rresp are forwarded unmodified; SLVERR/DECERR do not alter FSM flow.
- rst_n asserted mid-burst: immediate return to reset state. The MIG is reset by the same ui_rst, so no drain is required.

Decomposition:
- Shared package ddr_pkg holds:
  - AXI_BURST_INCR = 2'b01
  - the AXI response encodings
  - the clog2 function
  - the write FSM state typedef/localparams
  - the read FSM state typedef/localparams
- One sub-module, rr_arbiter (parameter N), instantiated twice (write and read):
  - inputs: req[N], ptr
  - output: one-hot grant plus encoded index, combinational.

Test Plan:
- NUM_PORTS=4; port 2 alone issues a write, awaddr=0x100, awlen=7 -> m_awid=2, m_awaddr=0x100, 8 beats forwarded in order, B routed only to port 2, wr_ptr=3.
- All 4 ports assert awvalid at once, each awlen=3 -> grant order 0,1,2,3; then port 0 re-requests -> granted only after port 3's B handshake.
- Concurrent port 1 write (awlen=15) and port 3 read (arlen=15) -> both bursts overlap on the MIG; no cross-routing; rd_grant=3, wr_grant=1 throughout.
- awlen=0 single-beat write with m_wready stalled 5 cycles -> m_wvalid held, s_wready[g]=0 until m_wready, FSM reaches W_RESP after one beat.
- m_rresp=2'b10 on beat 3 of an 8-beat read -> SLVERR forwarded on s_rresp, burst still completes on rlast, FSM returns to R_IDLE.
- rst_n pulsed low at beat 4 of an 8-beat write -> all outputs 0 next edge, FSMs in IDLE, pointers 0; a new write afterwards is granted normally.
